// File: rtl/prog_loader.sv
// Program-memory loader: parses SYNC/LEN/DATA/CSUM frames from a byte stream,
// writes the image into program memory and releases CPU reset on a good checksum.
module prog_loader #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
  parameter int                TIMEOUT   = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              pm_wen_o,
  output logic [ADDR_W-1:0] pm_addr_o,
  output logic [DATA_W-1:0] pm_data_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = ADDR_W + 1;
  localparam logic [DATA_W:0] MAX_LEN = (DATA_W+1)'(2**ADDR_W);

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_LEN  = 2'b01;
  localparam logic [1:0] E_CSUM = 2'b10;
  localparam logic [1:0] E_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [1:0]        err_n;
  logic [IW-1:0]     len_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] sum_q;
  logic [CW-1:0]     tmo_q;

  logic              take;
  logic              is_sync;
  logic              in_frame;
  logic              tmo_hit;
  logic              len_ok;
  logic              last_data;
  logic [DATA_W:0]   len_ext;
  logic [DATA_W-1:0] csum_chk;

  assign take      = rx_valid_i & rx_ready_o;
  assign is_sync   = (rx_data_i == SYNC_BYTE);
  assign in_frame  = (state == S_LEN) ||
                     (state == S_DATA) ||
                     (state == S_CSUM);
  // accept wins over an expiring counter
  assign tmo_hit   = !take &&
                     (tmo_q == CW'(TIMEOUT - 1));
  assign len_ext   = {1'b0, rx_data_i};
  assign len_ok    = (len_ext != '0) &&
                     (len_ext <= MAX_LEN);
  assign last_data = (idx_q == len_q - 1'b1);
  assign csum_chk  = sum_q + rx_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt   = state;
    err_n = err_o;
    unique case (state)
      S_IDLE: begin
        if (take && is_sync) begin
          nxt   = S_LEN;
          err_n = E_NONE;
        end
      end
      S_LEN: begin
        if (take) begin
          if (len_ok) begin
            nxt = S_DATA;
          end else begin
            nxt   = S_ERR;
            err_n = E_LEN;
          end
        end else if (tmo_hit) begin
          nxt   = S_ERR;
          err_n = E_TMO;
        end
      end
      S_DATA: begin
        if (take) begin
          if (last_data) begin
            nxt = S_CSUM;
          end
        end else if (tmo_hit) begin
          nxt   = S_ERR;
          err_n = E_TMO;
        end
      end
      S_CSUM: begin
        if (take) begin
          if (csum_chk == '0) begin
            nxt = S_DONE;
          end else begin
            nxt   = S_ERR;
            err_n = E_CSUM;
          end
        end else if (tmo_hit) begin
          nxt   = S_ERR;
          err_n = E_TMO;
        end
      end
      S_DONE: begin
        nxt = S_IDLE;
      end
      S_ERR: begin
        if (take && is_sync) begin
          nxt   = S_LEN;
          err_n = E_NONE;
        end
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_ready_o <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= E_NONE;
      cpu_rst_o  <= 1'b1;
    end else begin
      rx_ready_o <= (nxt != S_DONE);
      busy_o     <= (nxt == S_LEN) ||
                    (nxt == S_DATA) ||
                    (nxt == S_CSUM);
      done_o     <= (nxt == S_DONE);
      err_o      <= err_n;
      if (nxt == S_DONE) begin
        cpu_rst_o <= 1'b0;
      end else if (nxt == S_LEN && !in_frame) begin
        cpu_rst_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pm_wen_o  <= 1'b0;
      pm_addr_o <= '0;
      pm_data_o <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
    end else begin
      pm_wen_o <= (state == S_DATA) && take;
      if (state == S_LEN && take) begin
        len_q <= rx_data_i[IW-1:0];
        idx_q <= '0;
        sum_q <= '0;
      end
      if (state == S_DATA && take) begin
        pm_addr_o <= idx_q[ADDR_W-1:0];
        pm_data_o <= rx_data_i;
        idx_q     <= idx_q + 1'b1;
        sum_q     <= csum_chk;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else if (!in_frame || take) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: frames are scored by a rule-based
// frame predictor and a write monitor.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       pm_wen;
  logic [4:0] pm_addr;
  logic [7:0] pm_data;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;
  int dones = 0;
  logic [12:0] wq[$];

  prog_loader dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .pm_wen_o  (pm_wen),
    .pm_addr_o (pm_addr),
    .pm_data_o (pm_data),
    .cpu_rst_o (cpu_rst),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pm_wen) begin
        wq.push_back({pm_addr, pm_data});
        check("wen_busy", busy, 1);
      end
      if (done) begin
        dones++;
        check("done_rdy", rx_ready, 0);
      end
      if (!rx_ready) check("rdy_done", done, 1);
    end
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    logic acc;
    idle(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 8);
    if (!acc) check("accept", 0, 1);
    rx_valid = 1'b0;
  endtask

  task automatic play(input bq_t q, input int maxgap, input int tail);
    foreach (q[i]) send(q[i], $urandom_range(0, maxgap));
    idle(tail);
  endtask

  task automatic garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send(b, $urandom_range(0, 3));
    end
  endtask

  // Frame outcome from the framing rules; q[0] is the sync byte.
  task automatic predict(input bq_t q, output bq_t w,
                         output logic [1:0] e, output logic c,
                         output int dn);
    int len;
    int nd;
    logic [7:0] s;
    w = {};
    dn = 0;
    c = 1'b1;
    len = int'(q[1]);
    if (len == 0 || len > 32) begin
      e = 2'b01;
    end else begin
      nd = q.size() - 2;
      if (nd > len) nd = len;
      for (int i = 0; i < nd; i++) w.push_back(q[2+i]);
      if (q.size() < len + 3) begin
        e = 2'b11;
      end else begin
        s = '0;
        for (int i = 0; i <= len; i++) s = s + q[2+i];
        if (s == 8'h00) begin
          e = 2'b00;
          c = 1'b0;
          dn = 1;
        end else begin
          e = 2'b10;
        end
      end
    end
  endtask

  task automatic verify(input string tag, input bq_t d,
                        input logic [1:0] e, input logic c,
                        input int dn);
    idle(4);
    check({tag, "_nwr"}, wq.size(), d.size());
    for (int i = 0; i < wq.size() && i < d.size(); i++) begin
      check({tag, "_wa"}, wq[i][12:8], i);
      check({tag, "_wd"}, wq[i][7:0], d[i]);
    end
    check({tag, "_err"}, err, e);
    check({tag, "_cpu"}, cpu_rst, c);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, dones, dn);
    wq.delete();
    dones = 0;
  endtask

  task automatic frame(input string tag, input bq_t q,
                       input int maxgap, input int tail);
    bq_t w;
    logic [1:0] e;
    logic c;
    int dn;
    predict(q, w, e, c, dn);
    play(q, maxgap, tail);
    verify(tag, w, e, c, dn);
  endtask

  task automatic rst_vals(input string tag);
    check({tag, "_rdy"}, rx_ready, 1);
    check({tag, "_wen"}, pm_wen, 0);
    check({tag, "_addr"}, pm_addr, 0);
    check({tag, "_data"}, pm_data, 0);
    check({tag, "_cpu"}, cpu_rst, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    bq_t q;
    int len;
    int kind;
    int tail;
    logic [7:0] s;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1;
    rst_vals("rst");
    rst = 1'b0;
    idle(2);

    frame("t1", '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A}, 2, 0);
    frame("t2", '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}, 2, 0);
    frame("t3a", '{8'hA5, 8'h21}, 2, 0);
    frame("t3b", '{8'hA5, 8'h01, 8'h7F, 8'h81}, 2, 0);

    frame("t4a", '{8'hA5, 8'h02, 8'h11}, 0, 255);
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h11, 0);
    send(8'h22, 254);
    check("t4b_busy", busy, 1);
    send(8'hCD, 0);
    verify("t4b", '{8'h11, 8'h22}, 2'b00, 1'b0, 1);

    garbage(0);
    send(8'h00, 1);
    send(8'hFF, 0);
    send(8'h3C, 2);
    send(8'hA5, 0);
    send(8'h01, 0);
    @(negedge clk);
    check("t5_reload_cpu", cpu_rst, 1);
    check("t5_reload_busy", busy, 1);
    send(8'h55, 1);
    send(8'hAB, 0);
    verify("t5", '{8'h55}, 2'b00, 1'b0, 1);

    play('{8'hA5, 8'h04, 8'h01, 8'h02}, 0, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    rst_vals("t6rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    verify("t6a", '{8'h01, 8'h02}, 2'b00, 1'b1, 0);
    frame("t6b", '{8'hA5, 8'h02, 8'h40, 8'h41, 8'h7F}, 2, 0);

    for (int n = 0; n < 40; n++) begin
      garbage($urandom_range(0, 2));
      len = $urandom_range(1, 32);
      q = '{8'hA5, 8'(len)};
      s = '0;
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        q.push_back(d);
        s = s + d;
      end
      kind = $urandom_range(0, 5);
      tail = 0;
      if (kind == 1) begin
        q.push_back(8'(-s + 8'($urandom_range(1, 255))));
      end else begin
        q.push_back(8'(-s));
      end
      if (kind == 2) begin
        q[1] = ($urandom_range(0, 1) == 1) ? 8'h00 :
               8'($urandom_range(33, 255));
        while (q.size() > 2) void'(q.pop_back());
      end
      if (kind == 3) begin
        len = 2 + $urandom_range(0, len - 1);
        while (q.size() > len) void'(q.pop_back());
        tail = 260;
      end
      frame("rnd", q, 3, tail);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
